// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Word-aligned load/store sequencer for big-endian data memory.
//            Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================

package lsu_pkg;
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } load_store_func_code;
endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int GNT_TIMEOUT = 16,
    parameter int CNT_WIDTH   = $clog2(GNT_TIMEOUT + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                lsu_req_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [31:0]         lsu_addr_ip,
    input  logic [31:0]         lsu_wdata_ip,
    output logic                lsu_busy_op,
    output logic                lsu_done_op,
    output logic [31:0]         lsu_rdata_op,
    output logic                lsu_timeout_op,
    output logic                data_req_op,
    output logic [31:0]         data_addr_op,
    output logic [31:0]         wdata_op,
    output load_store_func_code lsu_operator_op,
    input  logic                mem_gnt_ip,
    input  logic [31:0]         load_data_ip
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                lsu_misalign_op
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(GNT_TIMEOUT - 1);

    state_t              r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    load_store_func_code r_op;
    logic [1:0]          r_k;
    logic                r_busy;
    logic                r_done;
    logic [31:0]         r_rdata;
    logic                r_timeout;
    logic                r_req;
    logic [31:0]         r_maddr;
    logic [31:0]         r_wdata;
    load_store_func_code r_mop;
    logic [31:0]         w_req_addr;

    function automatic logic is_load(input load_store_func_code op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    // Byte lanes are big-endian: lane 0 sits in word[31:24].
    function automatic logic [31:0] fmt_load(input load_store_func_code op,
                                             input logic [1:0]          k,
                                             input logic [31:0]         word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (k)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = k[1] ? word[15:0] : word[31:16];
        case (op)
            LB:      res = {{24{b[7]}}, b};
            LBU:     res = {24'd0, b};
            LH:      res = {{16{h[15]}}, h};
            LHU:     res = {16'd0, h};
            LW:      res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Only byte stores keep the full address; everything else is word aligned.
    assign w_req_addr = (lsu_operator_ip == SB) ? lsu_addr_ip : {lsu_addr_ip[31:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;
    logic w_misalign;

    assign w_misalign = (((lsu_operator_ip == LH) || (lsu_operator_ip == LHU) ||
                          (lsu_operator_ip == SH)) && lsu_addr_ip[0]) ||
                        (((lsu_operator_ip == LW) || (lsu_operator_ip == SW)) &&
                          (lsu_addr_ip[1:0] != 2'b00));
    assign lsu_misalign_op = r_misalign;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= LW;
            r_k       <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 32'd0;
            r_timeout <= 1'b0;
            r_req     <= 1'b0;
            r_maddr   <= 32'd0;
            r_wdata   <= 32'd0;
            r_mop     <= LW;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_ip) begin
                        r_op   <= lsu_operator_ip;
                        r_k    <= lsu_addr_ip[1:0];
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_state    <= S_RESP;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                        end else
`endif
                        begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_maddr <= w_req_addr;
                            r_wdata <= lsu_wdata_ip;
                            r_mop   <= is_load(lsu_operator_ip) ? LW : lsu_operator_ip;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_ip || (r_cnt == c_cnt_last)) begin
                        r_state   <= S_RESP;
                        r_done    <= 1'b1;
                        r_req     <= 1'b0;
                        r_maddr   <= 32'd0;
                        r_wdata   <= 32'd0;
                        r_mop     <= LW;
                        r_timeout <= !mem_gnt_ip;
                        r_rdata   <= (mem_gnt_ip && is_load(r_op)) ?
                                     fmt_load(r_op, r_k, load_data_ip) : 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_rdata   <= 32'd0;
                    r_timeout <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_misalign <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy_op     = r_busy;
    assign lsu_done_op     = r_done;
    assign lsu_rdata_op    = r_rdata;
    assign lsu_timeout_op  = r_timeout;
    assign data_req_op     = r_req;
    assign data_addr_op    = r_maddr;
    assign wdata_op        = r_wdata;
    assign lsu_operator_op = r_mop;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int c_gnt_timeout = 16;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                lsu_req_ip = 1'b0;
    load_store_func_code lsu_operator_ip = LW;
    logic [31:0]         lsu_addr_ip = 32'd0;
    logic [31:0]         lsu_wdata_ip = 32'd0;
    logic                lsu_busy_op;
    logic                lsu_done_op;
    logic [31:0]         lsu_rdata_op;
    logic                lsu_timeout_op;
    logic                data_req_op;
    logic [31:0]         data_addr_op;
    logic [31:0]         wdata_op;
    load_store_func_code lsu_operator_op;
    logic                mem_gnt_ip = 1'b0;
    logic [31:0]         load_data_ip;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                lsu_misalign_op;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gnt_delay = 0;

    typedef struct {
        logic [31:0]         rdata;
        logic                tmo;
        logic                mis;
        int                  rcyc;
        int                  lat;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic                is_store;
        load_store_func_code mop;
        int                  issue_cyc;
    } exp_t;

    exp_t exp_q[$];

    load_store_unit #(.GNT_TIMEOUT(c_gnt_timeout)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .lsu_req_ip      (lsu_req_ip),
        .lsu_operator_ip (lsu_operator_ip),
        .lsu_addr_ip     (lsu_addr_ip),
        .lsu_wdata_ip    (lsu_wdata_ip),
        .lsu_busy_op     (lsu_busy_op),
        .lsu_done_op     (lsu_done_op),
        .lsu_rdata_op    (lsu_rdata_op),
        .lsu_timeout_op  (lsu_timeout_op),
        .data_req_op     (data_req_op),
        .data_addr_op    (data_addr_op),
        .wdata_op        (wdata_op),
        .lsu_operator_op (lsu_operator_op),
        .mem_gnt_ip      (mem_gnt_ip),
        .load_data_ip    (load_data_ip)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .lsu_misalign_op (lsu_misalign_op)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == 32'h10) return 32'h8011_22F3;
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign load_data_ip = mem_word(data_addr_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Expected response from the access rules: extract lanes by shifting
    // the big-endian word and extend with integer arithmetic.
    function automatic exp_t model(input load_store_func_code op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int delay);
        exp_t        e;
        logic [31:0] w;
        int          k;
        int          bval;
        int          hval;
        logic        store;
        w     = mem_word(addr);
        k     = int'(addr[1:0]);
        store = (op == SB) || (op == SH) || (op == SW);
        e.mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (((op == LH) || (op == LHU) || (op == SH)) && addr[0]) e.mis = 1'b1;
        if (((op == LW) || (op == SW)) && (addr[1:0] != 2'b00)) e.mis = 1'b1;
`endif
        e.is_store  = store;
        e.wdata     = wdata;
        e.addr      = (op == SB) ? addr : (addr & 32'hFFFF_FFFC);
        e.mop       = store ? op : LW;
        e.issue_cyc = 0;
        e.rdata     = 32'd0;
        if (e.mis) begin
            e.tmo  = 1'b0;
            e.rcyc = 0;
            e.lat  = 1;
        end else begin
            e.tmo  = (delay >= c_gnt_timeout);
            e.rcyc = e.tmo ? c_gnt_timeout : delay + 1;
            e.lat  = e.rcyc + 1;
            if (!e.tmo && !store) begin
                bval = int'((w >> (8 * (3 - k))) & 32'hFF);
                hval = int'((w >> ((k >= 2) ? 0 : 16)) & 32'hFFFF);
                case (op)
                    LB:      e.rdata = 32'((bval >= 128) ? bval - 256 : bval);
                    LBU:     e.rdata = 32'(bval);
                    LH:      e.rdata = 32'((hval >= 32768) ? hval - 65536 : hval);
                    LHU:     e.rdata = 32'(hval);
                    default: e.rdata = w;
                endcase
            end
        end
        return e;
    endfunction

    task automatic issue(input load_store_func_code op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clock);
        while (lsu_busy_op) begin
            // Junk on the request inputs while busy must be ignored.
            if (lsu_done_op) begin
                lsu_req_ip = 1'b0;
            end else begin
                lsu_req_ip      = 1'($urandom_range(0, 1));
                lsu_operator_ip = load_store_func_code'($urandom_range(0, 7));
                lsu_addr_ip     = $urandom;
                lsu_wdata_ip    = $urandom;
            end
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", n);
                lsu_req_ip = 1'b0;
                return;
            end
            @(negedge clock);
        end
        e           = model(op, addr, wdata, delay);
        e.issue_cyc = cyc;
        gnt_delay   = delay;
        lsu_operator_ip = op;
        lsu_addr_ip     = addr;
        lsu_wdata_ip    = wdata;
        lsu_req_ip      = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        lsu_req_ip = 1'b0;
    endtask

    // Memory grant: assert in the (gnt_delay+1)-th consecutive request cycle.
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(negedge clock);
            if (!reset_n || !data_req_op) begin
                rc = 0;
                mem_gnt_ip = 1'b0;
            end else begin
                mem_gnt_ip = (rc == gnt_delay);
                rc++;
            end
        end
    end

    initial begin : monitor
        int   rc;
        exp_t e;
        rc = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                rc = 0;
            end else begin
                if (data_req_op) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL stray_req: data_req_op=1 with no access outstanding");
                    end else begin
                        rc++;
                        check("req_addr", data_addr_op, exp_q[0].addr);
                        check("req_op", 32'(lsu_operator_op), 32'(exp_q[0].mop));
                        if (exp_q[0].is_store) check("req_wdata", wdata_op, exp_q[0].wdata);
                    end
                end
                if (lsu_done_op) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL stray_done: lsu_done_op=1 with no access outstanding");
                    end else begin
                        e = exp_q.pop_front();
                        check("done_rdata", lsu_rdata_op, e.rdata);
                        check("done_timeout", 32'(lsu_timeout_op), 32'(e.tmo));
                        check("done_req_low", 32'(data_req_op), 32'd0);
                        check("done_busy", 32'(lsu_busy_op), 32'd1);
                        check("req_cycles", 32'(rc), 32'(e.rcyc));
                        check("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
`ifdef LSU_MISALIGN_TRAP_EN
                        check("done_misalign", 32'(lsu_misalign_op), 32'(e.mis));
`endif
                    end
                    rc = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(lsu_busy_op), 32'd0);
        check({tag, "_done"}, 32'(lsu_done_op), 32'd0);
        check({tag, "_rdata"}, lsu_rdata_op, 32'd0);
        check({tag, "_timeout"}, 32'(lsu_timeout_op), 32'd0);
        check({tag, "_req"}, 32'(data_req_op), 32'd0);
        check({tag, "_addr"}, data_addr_op, 32'd0);
        check({tag, "_wdata"}, wdata_op, 32'd0);
        check({tag, "_op"}, 32'(lsu_operator_op), 32'(LW));
    endtask

    initial begin : stimulus
        int r;
        int delay;
        int n;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        issue(LW,  32'h10, 32'h0, 0);
        issue(LB,  32'h13, 32'h0, 0);
        issue(LBU, 32'h13, 32'h0, 1);
        issue(LH,  32'h10, 32'h0, 0);
        issue(LHU, 32'h12, 32'h0, 2);
        issue(SW,  32'h20, 32'hDEAD_BEEF, 3);
        issue(SB,  32'h23, 32'h0000_00A5, 0);
        issue(SH,  32'h22, 32'h0000_1234, 1);
        issue(LW,  32'h10, 32'h0, c_gnt_timeout);
        issue(LH,  32'h12, 32'h0, c_gnt_timeout - 1);
        issue(LW,  32'h11, 32'h0, 0);
        issue(LH,  32'h11, 32'h0, 0);

        // Reset in the middle of a request that would never be granted.
        issue(LW, 32'h40, 32'h0, 100);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_req_drop", 32'(data_req_op), 32'd0);
        check("rst_no_done", 32'(lsu_done_op), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        issue(LBU, 32'h11, 32'h0, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      delay = $urandom_range(0, 3);
            else if (r < 8) delay = $urandom_range(4, c_gnt_timeout - 1);
            else            delay = $urandom_range(c_gnt_timeout, c_gnt_timeout + 4);
            issue(load_store_func_code'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(16, 19)) : $urandom,
                  $urandom, delay);
            n = $urandom_range(0, 2);
            repeat (n) @(negedge clock);
        end

        n = 0;
        while ((exp_q.size() != 0) && (n < 60)) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d accesses without done, required 0", exp_q.size());
        end
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
